// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions for the SRAM responder: response codes,
// the widest supported transfer size, FSM state types and the address check.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

    // Out-of-window addresses take priority over an oversized transfer.
    // The offset compare is widened so MEM_WORDS*4 cannot overflow.
    function automatic logic [1:0] decode_resp(input logic [31:0] addr,
                                               input logic [2:0]  size,
                                               input logic [31:0] base,
                                               input logic [31:0] words);
        logic [31:0] off;
        off = addr - base;
        if ({2'b00, off} >= {words, 2'b00})
            return RESP_DECERR;
        else if (size > SIZE_WORD)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_delay_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded with 8'hA5.
// Supplies pseudo-random response latencies to the SRAM responder.
module axi_delay_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign o_lfsr = r_lfsr;

    // Shift in the feedback bit every enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_lfsr <= 8'hA5;
        else if (i_en)
            r_lfsr <= {r_lfsr[6:0], w_fb};
    end

endmodule

// File: rtl/axi_lite_sram.sv
// AXI-lite responder in front of a word-organised SRAM model.
// Independent read and write FSMs, one outstanding transaction each,
// with a programmable response latency.
// Build option: define AXI_SRAM_RAND_DELAY_EN to take each latency from an
// LFSR instead of RD_LAT/WR_LAT.
module axi_lite_sram
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          RD_LAT    = 1,
    parameter int          WR_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [31:0] r_mem [MEM_WORDS];

    // ---------------- read side signals ----------------
    rd_state_t          r_rd_state, w_rd_next;
    logic [31:0]        r_rd_addr;
    logic [2:0]         r_rd_size;
    logic [3:0]         r_rd_cnt;
    logic [3:0]         w_rd_lat;
    logic               w_ar_hs;
    logic               w_rd_sample;
    logic [31:0]        w_rd_addr_sel;
    logic [2:0]         w_rd_size_sel;
    logic [1:0]         w_rd_resp;
    logic [IDX_W-1:0]   w_rd_idx;

    // ---------------- write side signals ----------------
    wr_state_t          r_wr_state, w_wr_next;
    logic               r_aw_got, r_w_got;
    logic [31:0]        r_wr_addr;
    logic [2:0]         r_wr_size;
    logic [31:0]        r_wr_data;
    logic [3:0]         r_wr_strb;
    logic [3:0]         r_wr_cnt;
    logic [3:0]         w_wr_lat;
    logic               w_aw_hs, w_w_hs;
    logic               w_aw_have, w_w_have;
    logic               w_wr_start;
    logic               w_wr_commit;
    logic               w_mem_we;
    logic [31:0]        w_wr_addr_sel;
    logic [2:0]         w_wr_size_sel;
    logic [31:0]        w_wr_data_sel;
    logic [3:0]         w_wr_strb_sel;
    logic [1:0]         w_wr_resp;
    logic [IDX_W-1:0]   w_wr_idx;

    // ---------------- latency source ----------------
`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [7:0] w_lfsr;

    axi_delay_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_en   (1'b1),
        .o_lfsr (w_lfsr)
    );

    // When both directions load in the same cycle they take different nibbles.
    assign w_rd_lat = w_lfsr[3:0];
    assign w_wr_lat = (w_ar_hs && w_wr_start) ? w_lfsr[7:4] : w_lfsr[3:0];
`else
    assign w_rd_lat = 4'(RD_LAT);
    assign w_wr_lat = 4'(WR_LAT);
`endif

    // ---------------- read path ----------------
    assign arready = (r_rd_state == R_IDLE);
    assign rvalid  = (r_rd_state == R_RESP);
    assign w_ar_hs = arready && arvalid;

    // With zero latency the sample happens on the AR edge, so use the live bus.
    assign w_rd_addr_sel = (r_rd_state == R_IDLE) ? araddr : r_rd_addr;
    assign w_rd_size_sel = (r_rd_state == R_IDLE) ? arsize : r_rd_size;
    assign w_rd_resp     = decode_resp(w_rd_addr_sel, w_rd_size_sel, BASE_ADDR, 32'(MEM_WORDS));
    assign w_rd_idx      = IDX_W'((w_rd_addr_sel - BASE_ADDR) >> 2);

    // Read FSM next-state decode.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (arvalid) w_rd_next = (w_rd_lat == 4'd0) ? R_RESP : R_WAIT;
            R_WAIT:  if (r_rd_cnt == 4'd1) w_rd_next = R_RESP;
            R_RESP:  if (rready) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
        w_rd_sample = (w_rd_next == R_RESP) && (r_rd_state != R_RESP);
    end

    // Read FSM state, request capture, latency count and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rd_addr  <= '0;
            r_rd_size  <= '0;
            r_rd_cnt   <= '0;
            rdata      <= '0;
            rresp      <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_ar_hs) begin
                r_rd_addr <= araddr;
                r_rd_size <= arsize;
                r_rd_cnt  <= w_rd_lat;
            end else if (r_rd_state == R_WAIT) begin
                r_rd_cnt  <= r_rd_cnt - 4'd1;
            end
            // Sampling on the same edge as a write commit returns the old word.
            if (w_rd_sample) begin
                rresp <= w_rd_resp;
                rdata <= (w_rd_resp == RESP_OKAY) ? r_mem[w_rd_idx] : '0;
            end
        end
    end

    // ---------------- write path ----------------
    assign awready   = !r_aw_got;
    assign wready    = !r_w_got;
    assign bvalid    = (r_wr_state == W_RESP);
    assign w_aw_hs   = awvalid && !r_aw_got;
    assign w_w_hs    = wvalid && !r_w_got;
    assign w_aw_have = r_aw_got || w_aw_hs;
    assign w_w_have  = r_w_got || w_w_hs;

    assign w_wr_addr_sel = r_aw_got ? r_wr_addr : awaddr;
    assign w_wr_size_sel = r_aw_got ? r_wr_size : awsize;
    assign w_wr_data_sel = r_w_got  ? r_wr_data : wdata;
    assign w_wr_strb_sel = r_w_got  ? r_wr_strb : wstrb;
    assign w_wr_resp     = decode_resp(w_wr_addr_sel, w_wr_size_sel, BASE_ADDR, 32'(MEM_WORDS));
    assign w_wr_idx      = IDX_W'((w_wr_addr_sel - BASE_ADDR) >> 2);

    // Write FSM next-state decode and commit strobe.
    always_comb begin
        w_wr_next  = r_wr_state;
        w_wr_start = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_have && w_w_have) begin
                    w_wr_start = 1'b1;
                    w_wr_next  = (w_wr_lat == 4'd0) ? W_RESP : W_WAIT;
                end
            end
            W_WAIT:  if (r_wr_cnt == 4'd1) w_wr_next = W_RESP;
            W_RESP:  if (bready) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
        w_wr_commit = (w_wr_next == W_RESP) && (r_wr_state != W_RESP);
        // A write only lands on a clean, non-reset edge.
        w_mem_we    = w_wr_commit && (w_wr_resp == RESP_OKAY) && !rst;
    end

    // Write FSM state, channel capture flags, latency count and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_size  <= '0;
            r_wr_data  <= '0;
            r_wr_strb  <= '0;
            r_wr_cnt   <= '0;
            bresp      <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            if ((r_wr_state == W_RESP) && bready) begin
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_got  <= 1'b1;
                    r_wr_addr <= awaddr;
                    r_wr_size <= awsize;
                end
                if (w_w_hs) begin
                    r_w_got   <= 1'b1;
                    r_wr_data <= wdata;
                    r_wr_strb <= wstrb;
                end
            end
            if (w_wr_start)
                r_wr_cnt <= w_wr_lat;
            else if (r_wr_state == W_WAIT)
                r_wr_cnt <= r_wr_cnt - 4'd1;
            if (w_wr_commit)
                bresp <= w_wr_resp;
        end
    end

    // Byte-lane write into the SRAM array; contents are never reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_strb_sel[k])
                    r_mem[w_wr_idx][8*k +: 8] <= w_wr_data_sel[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram with a scoreboard: expected read
// and write responses are queued when a request is driven and compared when
// the responder presents them.
module tb_axi_lite_sram;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;
    localparam int          RL    = 1;
    localparam int          WL    = 1;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_lite_sram #(
        .BASE_ADDR (BASE),
        .MEM_WORDS (WORDS),
        .RD_LAT    (RL),
        .WR_LAT    (WL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arsize  (arsize),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awsize  (awsize),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [int];
    rd_exp_t     rd_q [$];
    logic [1:0]  wr_q [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] off;
        off = addr - BASE;
        if (off >= 32'(WORDS * 4)) return 2'b11;
        if (size > 3'b010)         return 2'b10;
        return 2'b00;
    endfunction

    function automatic int widx(input logic [31:0] addr);
        return int'((addr - BASE) >> 2);
    endfunction

    function automatic rd_exp_t mk_rd(input logic [31:0] addr, input logic [2:0] size);
        rd_exp_t e;
        e.resp = exp_resp(addr, size);
        e.data = '0;
        if (e.resp == 2'b00 && model.exists(widx(addr)))
            e.data = model[widx(addr)];
        return e;
    endfunction

    task automatic do_wr(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] size,
                         input int awd, input int wd);
        logic [1:0]  r;
        logic [1:0]  e;
        logic [31:0] word;
        bit          aw_done, w_done, aw_hit, w_hit;
        int          k, n;
        r = exp_resp(addr, size);
        wr_q.push_back(r);
        if (r == 2'b00) begin
            word = model.exists(widx(addr)) ? model[widx(addr)] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
            model[widx(addr)] = word;
        end
        @(posedge clk); #1;
        awaddr = addr; awsize = size; wdata = data; wstrb = strb;
        aw_done = 0; w_done = 0; k = 0;
        while (!(aw_done && w_done) && k < 40) begin
            awvalid = (k >= awd) && !aw_done;
            wvalid  = (k >= wd) && !w_done;
            @(negedge clk);
            if (aw_done) chk("awready_low", 32'(awready), 32'h0);
            if (w_done)  chk("wready_low", 32'(wready), 32'h0);
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hit) aw_done = 1;
            if (w_hit)  w_done = 1;
            k++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) begin
            chk("wr_hs_timeout", 32'h1, 32'h0);
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bvalid && n < 40);
        chk("b_lat", 32'(n), 32'(1 + WL));
        e = wr_q.pop_front();
        chk("bresp", 32'(bresp), 32'(e));
        @(posedge clk);
        @(negedge clk);
        chk("b_done_bvalid", 32'(bvalid), 32'h0);
        chk("b_done_readies", 32'({awready, wready}), 32'h3);
    endtask

    task automatic do_rd(input logic [31:0] addr, input logic [2:0] size, input int hold);
        rd_exp_t e;
        bit      hit;
        int      k, n;
        rd_q.push_back(mk_rd(addr, size));
        @(posedge clk); #1;
        araddr = addr; arsize = size; arvalid = 1; rready = (hold == 0);
        hit = 0; k = 0;
        while (!hit && k < 40) begin
            @(negedge clk);
            hit = arready;
            @(posedge clk); #1;
            k++;
        end
        arvalid = 0;
        if (!hit) begin
            chk("ar_hs_timeout", 32'h1, 32'h0);
            rready = 1;
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rvalid && n < 40);
        chk("r_lat", 32'(n), 32'(1 + RL));
        e = rd_q.pop_front();
        chk("rdata", rdata, e.data);
        chk("rresp", 32'(rresp), 32'(e.resp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_rvalid", 32'(rvalid), 32'h1);
            chk("hold_rdata", rdata, e.data);
            chk("hold_rresp", 32'(rresp), 32'(e.resp));
            chk("hold_arready", 32'(arready), 32'h0);
        end
        rready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("r_done_arready", 32'(arready), 32'h1);
        chk("r_done_rvalid", 32'(rvalid), 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_exp_t     e;
        logic [1:0]  be;
        logic [31:0] newv;
        logic [31:0] ra;
        int          n;

        rst = 1; arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
        araddr = '0; arsize = 3'b010; awaddr = '0; awsize = 3'b010; wdata = '0; wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_readies", 32'({arready, awready, wready}), 32'h7);
        chk("rst_valids", 32'({rvalid, bvalid}), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_resps", 32'({rresp, bresp}), 32'h0);
        rst = 0;

        // Word write followed by readback.
        do_wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 0);
        do_rd(32'h8000_0010, 3'b010, 0);

        // Partial strobe, W three cycles ahead of AW.
        do_wr(32'h8000_0020, 32'h1122_3344, 4'hF, 3'b010, 0, 0);
        do_wr(32'h8000_0020, 32'h0000_AB00, 4'b0010, 3'b010, 3, 0);
        do_rd(32'h8000_0020, 3'b010, 0);
        chk("partial_model", model[8], 32'h1122_AB44);

        // Read back-pressure.
        do_rd(32'h8000_0010, 3'b010, 5);

        // Decode and size errors.
        do_wr(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 3'b010, 0, 0);
        do_wr(BASE + 32'(WORDS * 4), 32'h0BAD_0BAD, 4'hF, 3'b010, 0, 0);
        do_rd(32'h8000_0000, 3'b010, 0);
        do_rd(32'h7FFF_FFFC, 3'b010, 0);
        do_rd(32'h8000_0010, 3'b011, 0);
        do_wr(32'h8000_0010, 32'h1234_5678, 4'hF, 3'b100, 1, 0);
        do_rd(32'h8000_0010, 3'b010, 0);

        // Empty strobe is a no-op with OKAY.
        do_wr(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 3'b010, 0, 2);
        do_rd(32'h8000_0010, 3'b010, 0);

        // Collision on idx 5: read samples on the write-commit edge.
        do_wr(32'h8000_0014, 32'h5555_5555, 4'hF, 3'b010, 0, 0);
        newv = 32'hA5A5_0F0F;
        e.data = model[5]; e.resp = 2'b00;
        rd_q.push_back(e);
        model[5] = newv;
        wr_q.push_back(2'b00);
        @(posedge clk); #1;
        araddr = 32'h8000_0014; arsize = 3'b010;
        awaddr = 32'h8000_0014; awsize = 3'b010; wdata = newv; wstrb = 4'hF;
        arvalid = 1; awvalid = 1; wvalid = 1;
        @(negedge clk);
        chk("coll_readies", 32'({arready, awready, wready}), 32'h7);
        @(posedge clk); #1;
        arvalid = 0; awvalid = 0; wvalid = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rvalid && n < 40);
        chk("coll_r_lat", 32'(n), 32'(1 + RL));
        chk("coll_bvalid", 32'(bvalid), 32'h1);
        e = rd_q.pop_front();
        chk("coll_old_data", rdata, e.data);
        be = wr_q.pop_front();
        chk("coll_bresp", 32'(bresp), 32'(be));
        @(posedge clk);
        @(negedge clk);
        chk("coll_done", 32'({rvalid, bvalid}), 32'h0);
        do_rd(32'h8000_0014, 3'b010, 0);

        // Reset during R_WAIT and W_WAIT: responses dropped, no write lands.
        do_wr(32'h8000_0018, 32'h6666_0000, 4'hF, 3'b010, 0, 0);
        @(posedge clk); #1;
        araddr = 32'h8000_0014; arsize = 3'b010;
        awaddr = 32'h8000_0018; awsize = 3'b010; wdata = 32'hBAD0_BAD0; wstrb = 4'hF;
        arvalid = 1; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        arvalid = 0; awvalid = 0; wvalid = 0;
        #1 rst = 1;
        #1;
        chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
        chk("mid_rst_arready", 32'(arready), 32'h1);
        chk("mid_rst_bvalid", 32'(bvalid), 32'h0);
        chk("mid_rst_wr_readies", 32'({awready, wready}), 32'h3);
        chk("mid_rst_rdata", rdata, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_valids", 32'({rvalid, bvalid}), 32'h0);
        @(negedge clk);
        chk("post_rst_valids2", 32'({rvalid, bvalid}), 32'h0);
        do_rd(32'h8000_0014, 3'b010, 0);
        do_rd(32'h8000_0018, 3'b010, 0);

        // Randomised mix over a few pre-initialised words.
        for (int i = 8; i < 12; i++)
            do_wr(BASE + 32'(4 * i), $urandom, 4'hF, 3'b010, 0, 0);
        for (int i = 0; i < 8; i++) begin
            ra = BASE + 32'(4 * (8 + $urandom_range(0, 3)));
            do_wr(ra, $urandom, 4'($urandom_range(0, 15)), 3'b010,
                  $urandom_range(0, 3), $urandom_range(0, 3));
            do_rd(ra, 3'b010, $urandom_range(0, 2));
        end

        chk("rd_q_empty", 32'(rd_q.size()), 32'h0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
